// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the alu sharing arbiter
package alu_arb_pkg;

    localparam int NREQ_DEF = 3;
    localparam int IDW_DEF  = $clog2(NREQ_DEF);
    // Widest requester ID the response struct can carry (NREQ up to 8)
    localparam int IDW_MAX  = 3;

    localparam logic [3:0] EXE_ADD_OP  = 4'h0;
    localparam logic [3:0] EXE_SUB_OP  = 4'h1;
    localparam logic [3:0] EXE_AND_OP  = 4'h2;
    localparam logic [3:0] EXE_OR_OP   = 4'h3;
    localparam logic [3:0] EXE_XOR_OP  = 4'h4;
    localparam logic [3:0] EXE_SLT_OP  = 4'h5;
    localparam logic [3:0] EXE_SLTU_OP = 4'h6;
    localparam logic [3:0] EXE_SLL_OP  = 4'h7;
    localparam logic [3:0] EXE_SRL_OP  = 4'h8;
    localparam logic [3:0] EXE_SRA_OP  = 4'h9;

    // Driven onto the alu when nobody is granted so no X reaches it
    localparam logic [3:0] ALU_IDLE_OP = EXE_ADD_OP;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [31:0]        data;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter import alu_arb_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        logic           found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap explicitly so non-power-of-two NREQ never indexes past the end
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IDW'(idx);
            if (en && !found && req[idx_w]) begin
                found      = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_idx    = idx_w;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares one alu between NREQ requesters, registered response
module alu_share_arb import alu_arb_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_op,
    input  logic [31:0]       alu_y,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    input  logic              rsp_ready
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            free;
    logic            any_gnt;
    rsp_t            rsp_q;
    logic            unused_id_bits;

    // The slot may be refilled in the same cycle it drains
    assign free    = !rsp_valid || rsp_ready;
    assign any_gnt = |gnt;
    assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    rr_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    // gnt is one-hot, so at most one requester's fields reach the alu
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_IDLE_OP;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                alu_a  = req_a[32*i +: 32];
                alu_b  = req_b[32*i +: 32];
                alu_op = req_op[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            ptr       <= '0;
        end else if (any_gnt) begin
            rsp_valid  <= 1'b1;
            rsp_q.id   <= IDW_MAX'(gnt_idx);
            rsp_q.data <= alu_y;
            ptr        <= ptr_nxt;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_id         = rsp_q.id[IDW-1:0];
    assign rsp_data       = rsp_q.data;
    assign unused_id_bits = ^rsp_q.id;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic [11:0] req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_y;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    int total = 0;
    int bad   = 0;

    alu_share_arb #(.NREQ(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference alu; shift amount lives in b[24:20]
    always_comb begin
        case (alu_op)
            EXE_ADD_OP:  alu_y = alu_a + alu_b;
            EXE_SUB_OP:  alu_y = alu_a - alu_b;
            EXE_AND_OP:  alu_y = alu_a & alu_b;
            EXE_OR_OP:   alu_y = alu_a | alu_b;
            EXE_XOR_OP:  alu_y = alu_a ^ alu_b;
            EXE_SLT_OP:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            EXE_SLTU_OP: alu_y = {31'd0, alu_a < alu_b};
            EXE_SLL_OP:  alu_y = alu_a << alu_b[24:20];
            EXE_SRL_OP:  alu_y = alu_a >> alu_b[24:20];
            EXE_SRA_OP:  alu_y = $unsigned($signed(alu_a) >>> alu_b[24:20]);
            default:     alu_y = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
    endtask

    // A requester left waiting at one edge must still be there, unchanged, at the next
    logic [2:0]  pend;
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [3:0]  pop [3];
    initial pend = '0;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) begin
                chk("hold_valid", {31'd0, req_valid[i]}, 32'd1);
                chk("hold_a", req_a[32*i +: 32], pa[i]);
                chk("hold_b", req_b[32*i +: 32], pb[i]);
                chk("hold_op", {28'd0, req_op[4*i +: 4]}, {28'd0, pop[i]});
            end
            pa[i]  = req_a[32*i +: 32];
            pb[i]  = req_b[32*i +: 32];
            pop[i] = req_op[4*i +: 4];
        end
        pend = rst_n ? (req_valid & ~req_ready) : 3'b000;
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        chk("idle_op", {28'd0, alu_op}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request, same-cycle ready, next-cycle response, then drain
        set_req(1, 32'd5, 32'd3, EXE_SUB_OP);
        #1;
        chk("single_ready", {29'd0, req_ready}, 32'b010);
        chk("single_alu_a", alu_a, 32'd5);
        tick();
        drop(1);
        chk("single_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_id", {30'd0, rsp_id}, 32'd1);
        chk("single_data", rsp_data, 32'd2);
        tick();
        chk("drain_valid", {31'd0, rsp_valid}, 32'd0);
        chk("drain_data_hold", rsp_data, 32'd2);

        // Pointer wrap: req 2 alone, then 0 and 2 together
        set_req(2, 32'd7, 32'd1, EXE_ADD_OP);
        #1;
        chk("wrap_ready2", {29'd0, req_ready}, 32'b100);
        tick();
        drop(2);
        chk("wrap_data2", rsp_data, 32'd8);
        set_req(0, 32'd1, 32'd1, EXE_ADD_OP);
        set_req(2, 32'd20, 32'd2, EXE_SUB_OP);
        #1;
        chk("wrap_ready0", {29'd0, req_ready}, 32'b001);
        tick();
        drop(0);
        chk("wrap_id0", {30'd0, rsp_id}, 32'd0);
        chk("wrap_data0", rsp_data, 32'd2);
        #1;
        chk("wrap_ready2b", {29'd0, req_ready}, 32'b100);
        tick();
        drop(2);
        chk("wrap_id2b", {30'd0, rsp_id}, 32'd2);
        chk("wrap_data2b", rsp_data, 32'd18);

        // Fairness: all valid, one result per cycle, no bubbles
        for (int i = 0; i < 3; i++) set_req(i, i, 32'd10, EXE_ADD_OP);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", {29'd0, req_ready}, 32'd1 << (k % 3));
            tick();
            if (k >= 3) drop(k % 3);
            chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rr_id", {30'd0, rsp_id}, k % 3);
            chk("rr_data", rsp_data, 32'd10 + (k % 3));
        end
        tick();

        // Backpressure: response held, no grants, req 2 waits
        set_req(0, 32'hFFFF_FFFF, 32'd1, EXE_SLT_OP);
        tick();
        drop(0);
        rsp_ready = 1'b0;
        set_req(2, 32'd100, 32'd5, EXE_ADD_OP);
        chk("bp_data0", rsp_data, 32'd1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_ready", {29'd0, req_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_id", {30'd0, rsp_id}, 32'd0);
            chk("bp_data", rsp_data, 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {29'd0, req_ready}, 32'b100);
        tick();
        drop(2);
        chk("bp_release_id", {30'd0, rsp_id}, 32'd2);
        chk("bp_release_data", rsp_data, 32'd105);

        // Arithmetic shift through the arbiter
        set_req(1, 32'h8000_0000, 32'h0040_0000, EXE_SRA_OP);
        tick();
        drop(1);
        chk("sra_id", {30'd0, rsp_id}, 32'd1);
        chk("sra_data", rsp_data, 32'hF800_0000);

        // Leave ptr at 1, so only a reset can make req 0 beat req 1
        set_req(0, 32'd3, 32'd4, EXE_ADD_OP);
        tick();
        drop(0);
        chk("pre_rst_data", rsp_data, 32'd7);
        rsp_ready = 1'b0;
        tick();
        chk("pre_rst_hold", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_id", {30'd0, rsp_id}, 32'd0);
        chk("arst_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 32'd1, 32'd2, EXE_ADD_OP);
        set_req(1, 32'd9, 32'd9, 4'hF);
        #1;
        chk("post_rst_ready", {29'd0, req_ready}, 32'b001);
        chk("post_rst_alu_a", alu_a, 32'd1);
        tick();
        drop(0);
        chk("post_rst_id", {30'd0, rsp_id}, 32'd0);
        chk("post_rst_data", rsp_data, 32'd3);
        #1;
        chk("undef_ready", {29'd0, req_ready}, 32'b010);
        chk("undef_op_pass", {28'd0, alu_op}, 32'hF);
        tick();
        drop(1);
        chk("undef_valid", {31'd0, rsp_valid}, 32'd1);
        chk("undef_id", {30'd0, rsp_id}, 32'd1);
        tick();
        chk("final_drain", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
